// File: rtl/switch_input_ctrl_if.sv
// CPU-side register access bus for the switch input block.
// The master drives the strobes and the select; the slave returns the data and the flags.
interface switch_input_ctrl_if;
  logic        sw_ctrl;
  logic        io_read;
  logic [1:0]  sel;
  logic [15:0] rdata;
  logic        data_valid;
  logic        overrun;

  modport master (output sw_ctrl, io_read, sel, input rdata, data_valid, overrun);
  modport slave  (input sw_ctrl, io_read, sel, output rdata, data_valid, overrun);
endinterface

// File: rtl/switch_input_ctrl.sv
// Debounced confirm button that captures the 24 board switches into a one-deep buffer.
// The CPU reads the buffer and its status through the switch I/O register window.
//
//   state | meaning
//   EMPTY | no unconsumed sample in buf
//   FULL  | buf holds a sample not yet consumed by a high-half read
module switch_input_ctrl #(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 17
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [23:0]         switches,
  input  logic                confirm_btn,
  switch_input_ctrl_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic             sync_1;
  logic             btn_s;
  logic             btn_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_done;
  logic             press;

  state_t      state_q, state_d;
  logic [23:0] buf_q;
  logic        ovr_q;
  logic [15:0] rdata_q;
  logic [15:0] rd_mux;
  logic        rd;
  logic        clr_ovr;
  logic        load_buf;
  logic        set_ovr;
  logic        consume;

  // The press pulse is the cycle in which btn_db is about to rise, so the
  // capture lands on the same edge as the debounced transition.
  assign db_done = (btn_s != btn_db) && (db_cnt == CNT_W'(DB_CYCLES - 1));
  assign press   = db_done && btn_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_1 <= confirm_btn;
      btn_s  <= sync_1;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_done) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rd      = bus.sw_ctrl && bus.io_read;
  assign clr_ovr = rd && (bus.sel == 2'b10);

  always_comb begin
    state_d  = state_q;
    load_buf = 1'b0;
    set_ovr  = 1'b0;
    consume  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (press) begin
          load_buf = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        consume = rd && (bus.sel == 2'b01);
        if (press) begin
          load_buf = 1'b1;
          set_ovr  = !consume;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.sel)
      2'b00:   rd_mux = buf_q[15:0];
      2'b01:   rd_mux = {8'h00, buf_q[23:16]};
      2'b10:   rd_mux = {14'b0, ovr_q, (state_q == FULL)};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      buf_q   <= 24'h000000;
      ovr_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load_buf) buf_q <= switches;
      // A new overwrite in the same cycle as a status read keeps the flag set.
      if (set_ovr) ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
      if (rd) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.data_valid = (state_q == FULL);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl with DB_CYCLES=4: directed scenarios plus random traffic
// checked every cycle against a sample-and-buffer reference model.
module tb_switch_input_ctrl;

  localparam int DB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] switches = '0;
  logic        confirm_btn = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  switch_input_ctrl_if bus_if ();

  switch_input_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .switches    (switches),
    .confirm_btn (confirm_btn),
    .bus         (bus_if.slave)
  );

  always #5 clock = ~clock;

  // Reference: button seen two edges late; level accepted after DB straight differing edges.
  bit          m_d1, m_d2, m_stable, m_press, m_set, m_take;
  int          m_run;
  logic [23:0] m_buf;
  bit          m_valid, m_ovr;
  logic [15:0] m_rdata;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_d1 = 0; m_d2 = 0; m_stable = 0; m_run = 0;
      m_buf = '0; m_valid = 0; m_ovr = 0; m_rdata = '0;
    end else begin
      m_press = 0;
      if (m_d2 != m_stable) begin
        m_run = m_run + 1;
        if (m_run == DB) begin
          m_stable = m_d2;
          m_run = 0;
          m_press = m_stable;
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = confirm_btn;

      m_take = 0;
      if (bus_if.sw_ctrl && bus_if.io_read) begin
        if (bus_if.sel == 2'd0)      m_rdata = m_buf[15:0];
        else if (bus_if.sel == 2'd1) m_rdata = {8'h00, m_buf[23:16]};
        else if (bus_if.sel == 2'd2) m_rdata = {14'b0, m_ovr, m_valid};
        else                         m_rdata = 16'h0000;
        m_take = (bus_if.sel == 2'd1) && m_valid;
      end
      m_set = m_press && m_valid && !m_take;
      if (bus_if.sw_ctrl && bus_if.io_read && bus_if.sel == 2'd2) m_ovr = 0;
      if (m_set) m_ovr = 1;
      if (m_press) begin
        m_buf = switches;
        m_valid = 1;
      end else if (m_take) begin
        m_valid = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    check_val("rdata_model", bus_if.rdata, m_rdata);
    check_val("valid_model", bus_if.data_valid, m_valid);
    check_val("ovr_model", bus_if.overrun, m_ovr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_val("rst_rdata", bus_if.rdata, 16'h0000);
    check_val("rst_valid", bus_if.data_valid, 1'b0);
    check_val("rst_ovr", bus_if.overrun, 1'b0);
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic do_press(input logic [23:0] sw);
    switches = sw;
    confirm_btn = 1'b1;
    repeat (DB + 4) step();
    confirm_btn = 1'b0;
    repeat (DB + 4) step();
  endtask

  task automatic do_read(input logic [1:0] s);
    bus_if.sw_ctrl = 1'b1;
    bus_if.io_read = 1'b1;
    bus_if.sel = s;
    step();
    bus_if.sw_ctrl = 1'b0;
    bus_if.io_read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.sw_ctrl = 1'b0;
    bus_if.io_read = 1'b0;
    bus_if.sel = 2'b00;
    do_reset();

    // basic capture and latency
    switches = 24'hA5C3F0;
    confirm_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) check_val("dv_early", bus_if.data_valid, 1'b0);
      if (i == 6) check_val("dv_rise", bus_if.data_valid, 1'b1);
    end
    confirm_btn = 1'b0;
    repeat (8) step();
    do_read(2'b00);
    check_val("rd_low", bus_if.rdata, 16'hC3F0);
    do_read(2'b01);
    check_val("rd_high", bus_if.rdata, 16'h00A5);
    check_val("dv_consumed", bus_if.data_valid, 1'b0);

    // glitches shorter than the debounce window
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      confirm_btn = 1'b1;
      repeat (w) step();
      confirm_btn = 1'b0;
      repeat (2) step();
      check_val("glitch_dv", bus_if.data_valid, 1'b0);
    end
    repeat (6) step();
    do_read(2'b00);
    check_val("glitch_low", bus_if.rdata, 16'h0000);
    do_read(2'b01);
    check_val("glitch_high", bus_if.rdata, 16'h0000);

    // overrun and status reads
    do_reset();
    do_press(24'h000011);
    do_press(24'h000022);
    check_val("ovr_set", bus_if.overrun, 1'b1);
    do_read(2'b10);
    check_val("stat_1", bus_if.rdata, 16'h0003);
    do_read(2'b10);
    check_val("stat_2", bus_if.rdata, 16'h0001);
    do_read(2'b00);
    check_val("ovr_low", bus_if.rdata, 16'h0022);

    // consuming read on the same edge as a press
    do_reset();
    do_press(24'h7E0011);
    switches = 24'h123456;
    confirm_btn = 1'b1;
    repeat (5) step();
    do_read(2'b01);
    check_val("coin_rdata", bus_if.rdata, 16'h007E);
    check_val("coin_dv", bus_if.data_valid, 1'b1);
    check_val("coin_ovr", bus_if.overrun, 1'b0);
    confirm_btn = 1'b0;
    repeat (8) step();
    do_read(2'b00);
    check_val("coin_low", bus_if.rdata, 16'h3456);
    do_read(2'b01);
    check_val("coin_high", bus_if.rdata, 16'h0012);

    // unselected region and reserved register
    do_press(24'h00BEEF);
    do_read(2'b00);
    check_val("pre_unsel", bus_if.rdata, 16'hBEEF);
    bus_if.sw_ctrl = 1'b0;
    bus_if.io_read = 1'b1;
    bus_if.sel = 2'b01;
    step();
    bus_if.io_read = 1'b0;
    check_val("unsel_hold", bus_if.rdata, 16'hBEEF);
    check_val("unsel_dv", bus_if.data_valid, 1'b1);
    do_read(2'b11);
    check_val("rsvd_zero", bus_if.rdata, 16'h0000);
    check_val("rsvd_dv", bus_if.data_valid, 1'b1);

    // reset in the middle of a debounce while FULL with overrun
    do_press(24'h000001);
    check_val("pre_rst_ovr", bus_if.overrun, 1'b1);
    confirm_btn = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", bus_if.data_valid, 1'b0);
    check_val("mid_rst_ovr", bus_if.overrun, 1'b0);
    check_val("mid_rst_rdata", bus_if.rdata, 16'h0000);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) check_val("requal_early", bus_if.data_valid, 1'b0);
      if (i == 6) check_val("requal_rise", bus_if.data_valid, 1'b1);
    end
    confirm_btn = 1'b0;
    repeat (8) step();

    // random traffic against the model
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          confirm_btn = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 8);
        end
        hold--;
        switches = 24'($urandom);
        bus_if.sw_ctrl = ($urandom_range(0, 3) != 0);
        bus_if.io_read = 1'($urandom_range(0, 1));
        bus_if.sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 499) == 0) begin
          reset = 1'b1;
          #1;
          check_val("rnd_rst_valid", bus_if.data_valid, 1'b0);
          step();
          reset = 1'b0;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
